// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweep: steps {a,b,c} through 000..111 and holds each pattern for
// DWELL cycles. The function output d_in is captured into table_out on each pattern's last cycle.
module truth_table_sweeper #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       d_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       table_valid,
    output logic [7:0] table_out
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] dwell_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dwell_cnt   <= '0;
            table_valid <= 1'b0;
            table_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= DRIVE;
                        idx         <= '0;
                        dwell_cnt   <= '0;
                        table_out   <= '0;
                        table_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    // The last dwell cycle gives d_in the most settling time before capture.
                    if (dwell_cnt == LAST_CNT) begin
                        table_out[idx] <= d_in;
                        dwell_cnt      <= '0;
                        if (idx == 3'd7) begin
                            state <= DONE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    table_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {a, b, c} = idx;
    assign busy      = (state == DRIVE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four instances with DWELL = 4, 1, 3 and 2, each driven from a
// per-instance truth table or a 2-cycle delayed a&b&c model. Results are checked against a sample-time model.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start, d_in, a, b, c, busy, done, tv;
    logic [7:0] tbl [4];
    logic [7:0] tt [4];
    logic [3:0] use_dly, dl1, dl2;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.DWELL(4), .CNT_W(8)) u_dw4 (
        .clk(clk), .rst(rst), .start(start[0]), .d_in(d_in[0]), .a(a[0]), .b(b[0]), .c(c[0]),
        .busy(busy[0]), .done(done[0]), .table_valid(tv[0]), .table_out(tbl[0]));
    truth_table_sweeper #(.DWELL(1), .CNT_W(8)) u_dw1 (
        .clk(clk), .rst(rst), .start(start[1]), .d_in(d_in[1]), .a(a[1]), .b(b[1]), .c(c[1]),
        .busy(busy[1]), .done(done[1]), .table_valid(tv[1]), .table_out(tbl[1]));
    truth_table_sweeper #(.DWELL(3), .CNT_W(8)) u_dw3 (
        .clk(clk), .rst(rst), .start(start[2]), .d_in(d_in[2]), .a(a[2]), .b(b[2]), .c(c[2]),
        .busy(busy[2]), .done(done[2]), .table_valid(tv[2]), .table_out(tbl[2]));
    truth_table_sweeper #(.DWELL(2), .CNT_W(8)) u_dw2 (
        .clk(clk), .rst(rst), .start(start[3]), .d_in(d_in[3]), .a(a[3]), .b(b[3]), .c(c[3]),
        .busy(busy[3]), .done(done[3]), .table_valid(tv[3]), .table_out(tbl[3]));

    // Function under sweep: a lookup table, or a&b&c seen through a two-flop delay.
    always_comb begin
        for (int k = 0; k < 4; k++)
            d_in[k] = use_dly[k] ? dl2[k] : tt[k][{a[k], b[k], c[k]}];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dl1 <= '0;
            dl2 <= '0;
        end else begin
            dl1 <= a & b & c;
            dl2 <= dl1;
        end
    end

    function automatic int dw_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] tt_from(input int f);
        logic [7:0] r;
        int x, y, z;
        for (int i = 0; i < 8; i++) begin
            x = (i >> 2) & 1;
            y = (i >> 1) & 1;
            z = i & 1;
            case (f)
                0:       r[i] = 1'(x ^ y ^ z);
                1:       r[i] = 1'((x & y) | z);
                2:       r[i] = 1'b1;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Bit i is d at the capture time (last cycle of pattern i); with a delay of 'lag' cycles
    // that value belongs to whichever pattern was showing lag cycles earlier (0 before the sweep).
    function automatic logic [7:0] expect_tbl(input int k, input int lag);
        logic [7:0] r;
        int dw, s, p;
        dw = dw_of(k);
        for (int i = 0; i < 8; i++) begin
            s = i * dw + dw - 1 - lag;
            p = (s < 0) ? 0 : s / dw;
            r[i] = use_dly[k] ? (p == 7) : tt[k][p];
        end
        return r;
    endfunction

    task automatic run_sweep(input int k, input string name, input int lag, input bit poke);
        int dw, nbusy, ndone, perr;
        bit clr, poked5, pokedd;
        logic [7:0] exp_t;
        dw = dw_of(k);
        exp_t = expect_tbl(k, lag);
        repeat ($urandom_range(3, 0)) @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        n_cmp++;
        if (tv[k] !== 1'b0) begin
            n_err++; $display("FAIL %s valid_drop: got %b exp 0", name, tv[k]);
        end
        n_cmp++;
        if (tbl[k] !== 8'h00) begin
            n_err++; $display("FAIL %s table_clear: got %h exp 00", name, tbl[k]);
        end
        nbusy = 0; ndone = 0; perr = 0; clr = 0; poked5 = 0; pokedd = 0;
        for (int cyc = 0; cyc < 8 * dw + 6; cyc++) begin
            if (busy[k]) begin
                if ({a[k], b[k], c[k]} !== 3'(nbusy / dw)) perr++;
                nbusy++;
            end
            if (done[k]) ndone++;
            if (clr) begin
                start[k] = 1'b0;
                clr = 0;
            end else if (poke && busy[k] && !poked5 && {a[k], b[k], c[k]} == 3'd5) begin
                start[k] = 1'b1; clr = 1; poked5 = 1;
            end else if (poke && done[k] && !pokedd) begin
                start[k] = 1'b1; clr = 1; pokedd = 1;
            end
            @(negedge clk);
        end
        start[k] = 1'b0;
        n_cmp++;
        if (nbusy != 8 * dw) begin
            n_err++; $display("FAIL %s busy_len: got %0d exp %0d", name, nbusy, 8 * dw);
        end
        n_cmp++;
        if (perr != 0) begin
            n_err++; $display("FAIL %s pattern_order: got %0d bad cycles exp 0", name, perr);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_err++; $display("FAIL %s done_pulses: got %0d exp 1", name, ndone);
        end
        n_cmp++;
        if (tbl[k] !== exp_t) begin
            n_err++; $display("FAIL %s table_out: got %h exp %h", name, tbl[k], exp_t);
        end
        n_cmp++;
        if (tv[k] !== 1'b1 || busy[k] !== 1'b0) begin
            n_err++; $display("FAIL %s valid_idle: got valid=%b busy=%b exp valid=1 busy=0", name, tv[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; use_dly = '0;
        for (int k = 0; k < 4; k++) tt[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({a[k], b[k], c[k], busy[k], done[k], tv[k]} !== 6'b0 || tbl[k] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got abc=%b%b%b busy=%b done=%b valid=%b table=%h exp all 0",
                         k, a[k], b[k], c[k], busy[k], done[k], tv[k], tbl[k]);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 4'b0000) begin
            n_err++; $display("FAIL idle_no_start: got busy=%b exp 0000", busy);
        end
    endtask

    task automatic test_parity();
        tt[0] = tt_from(0);
        run_sweep(0, "parity_dw4", 0, 0);
    endtask

    task automatic test_mixed_min_dwell();
        tt[1] = tt_from(1);
        run_sweep(1, "mixed_dw1", 0, 0);
    endtask

    task automatic test_const_resweep();
        tt[0] = tt_from(2);
        run_sweep(0, "const1", 0, 0);
        tt[0] = tt_from(3);
        run_sweep(0, "const0_resweep", 0, 0);
    endtask

    task automatic test_ignored_starts();
        tt[0] = 8'($urandom);
        run_sweep(0, "ignored_starts", 0, 1);
    endtask

    task automatic test_settling();
        use_dly[2] = 1'b1;
        use_dly[3] = 1'b1;
        run_sweep(2, "settle_dw3", 2, 0);
        run_sweep(3, "settle_dw2", 2, 0);
    endtask

    task automatic test_back_to_back();
        int dones[$];
        logic [7:0] exp_t;
        tt[1] = 8'($urandom);
        exp_t = expect_tbl(1, 0);
        start[1] = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 35; cyc++) begin
            if (done[1]) dones.push_back(cyc);
            @(negedge clk);
        end
        start[1] = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (dones.size() != 3) begin
            n_err++; $display("FAIL b2b_done_count: got %0d exp 3", dones.size());
        end else begin
            n_cmp++;
            if (dones[0] != 8 || dones[1] - dones[0] != 10 || dones[2] - dones[1] != 10) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d,%0d,%0d exp 8,18,28", dones[0], dones[1], dones[2]);
            end
        end
        n_cmp++;
        if (tbl[1] !== exp_t || tv[1] !== 1'b1) begin
            n_err++; $display("FAIL b2b_table: got %h valid=%b exp %h valid=1", tbl[1], tv[1], exp_t);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bool_wait: begin end
        tt[0] = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 40 && {a[0], b[0], c[0]} != 3'd3; i++) @(negedge clk);
        n_cmp++;
        if ({a[0], b[0], c[0]} !== 3'd3) begin
            n_err++; $display("FAIL midrst_reach_idx3: got %b%b%b exp 011", a[0], b[0], c[0]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a[0], b[0], c[0], busy[0], done[0], tv[0]} !== 6'b0 || tbl[0] !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_async_clear: got abc=%b%b%b busy=%b done=%b valid=%b table=%h exp all 0",
                     a[0], b[0], c[0], busy[0], done[0], tv[0], tbl[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || tv[0] !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_autostart: got busy=%b valid=%b exp 0 0", busy[0], tv[0]);
        end
        tt[0] = 8'($urandom);
        run_sweep(0, "after_reset", 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            tt[0] = 8'($urandom);
            run_sweep(0, "rand_dw4", 0, 0);
            tt[1] = 8'($urandom);
            run_sweep(1, "rand_dw1", 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_mixed_min_dwell();
        test_const_resweep();
        test_ignored_starts();
        test_settling();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
